// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer.
//   state_t   : sequencer FSM states
//   NUM_KEYS  : number of colour keyframes in the loop
//   key_bits  : keyframe table as {r,g,b} on/off bits (on = full scale, off = 0)
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NUM_KEYS = 6;

    function automatic logic [2:0] key_bits(input logic [2:0] idx);
        case (idx)
            3'd0:    key_bits = 3'b100;  // red
            3'd1:    key_bits = 3'b110;  // yellow
            3'd2:    key_bits = 3'b010;  // green
            3'd3:    key_bits = 3'b011;  // cyan
            3'd4:    key_bits = 3'b001;  // blue
            3'd5:    key_bits = 3'b101;  // magenta
            default: key_bits = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output channel: shadow duty register plus compare.
//   clk, reset : clock, async active-low reset
//   enable     : output forced low on the cycle after enable is low
//   cnt        : shared free-running PWM counter
//   duty       : live duty; captured into the shadow only at cnt == full scale
//   pwm        : registered PWM output, high while cnt < shadow
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    logic [PWM_BITS-1:0] shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            // Loading at the last count of a period means a new duty only
            // takes effect at a period boundary.
            if (cnt == '1)
                shadow <= duty;
            pwm <= enable && (cnt < shadow);
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// RGB fade sequencer: ramps three PWM duties through a looping table of
// colour keyframes, one duty LSB per step tick, holding at each keyframe.
//   clk, reset : clock, async active-low reset
//   enable     : run while high; low returns to IDLE with duties cleared
//   pause      : freeze step progress (PWM keeps running)
//   rgb        : PWM outputs [2]=red [1]=green [0]=blue
//   duty       : current duties {r,g,b}
//   key_idx    : current target keyframe
//   holding    : high while holding at a keyframe
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 125_000,
    parameter int HOLD_STEPS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pause,
    output logic [2:0]            rgb,
    output logic [3*PWM_BITS-1:0] duty,
    output logic [2:0]            key_idx,
    output logic                  holding
);

    localparam int PRE_W  = $clog2(STEP_DIV + 1);
    localparam int HOLD_W = $clog2(HOLD_STEPS + 1);
    localparam logic [PWM_BITS-1:0] FS        = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [2:0]          LAST_KEY  = 3'(NUM_KEYS - 1);

    state_t                     state, state_nx;
    logic [2:0][PWM_BITS-1:0]   duty_q, duty_nx, target;
    logic [2:0]                 key_q, key_nx, key_on;
    logic [HOLD_W-1:0]          hold_q, hold_nx;
    logic [PRE_W-1:0]           pre_q;
    logic [PWM_BITS-1:0]        pwm_cnt;
    logic                       tick;

    // Step prescaler: only advances while the sequence is actually running.
    assign tick = enable && !pause && (state != IDLE) && (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pre_q <= '0;
        else if (!enable || state == IDLE)
            pre_q <= '0;
        else if (!pause)
            pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    end

    always_comb begin
        key_on = key_bits(key_q);
        for (int c = 0; c < 3; c++)
            target[c] = key_on[c] ? FS : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            duty_q <= '0;
            key_q  <= '0;
            hold_q <= '0;
        end else begin
            state  <= state_nx;
            duty_q <= duty_nx;
            key_q  <= key_nx;
            hold_q <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        duty_nx  = duty_q;
        key_nx   = key_q;
        hold_nx  = hold_q;
        if (!enable) begin
            // Dropping enable wins over any tick in the same cycle.
            state_nx = IDLE;
            duty_nx  = '0;
            key_nx   = '0;
            hold_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = RAMP;
                    duty_nx  = '0;
                    key_nx   = '0;
                    hold_nx  = '0;
                end
                RAMP: if (tick) begin
                    if (duty_q == target) begin
                        state_nx = HOLD;
                        hold_nx  = '0;
                    end else begin
                        for (int c = 0; c < 3; c++) begin
                            if (duty_q[c] < target[c])
                                duty_nx[c] = duty_q[c] + PWM_BITS'(1);
                            else if (duty_q[c] > target[c])
                                duty_nx[c] = duty_q[c] - PWM_BITS'(1);
                        end
                    end
                end
                HOLD: if (tick) begin
                    // HOLD_STEPS ticks are spent here before moving on.
                    if (hold_q == HOLD_LAST) begin
                        key_nx   = (key_q == LAST_KEY) ? 3'd0 : key_q + 3'd1;
                        state_nx = RAMP;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_q + HOLD_W'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .cnt    (pwm_cnt),
            .duty   (duty_q[c]),
            .pwm    (rgb[c])
        );
    end

    assign duty    = duty_q;
    assign key_idx = key_q;
    assign holding = (state == HOLD);

endmodule
